// File: rtl/sign_class_pkg.sv
// Shared types and default widths for the sign-classification arbiter slice.
package sign_class_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_CNT_W   = 8;

  typedef enum logic [1:0] {SC_ZERO, SC_POS, SC_NEG} sign_class_e;

  typedef enum logic [1:0] {ST_IDLE, ST_CLASSIFY, ST_RESP} state_e;

  function automatic sign_class_e flags_to_class(input logic pos, input logic neg);
    if (neg)      return SC_NEG;
    else if (pos) return SC_POS;
    else          return SC_ZERO;
  endfunction

endpackage

// File: rtl/sign_classifier.sv
// Registered sign classifier: one-cycle latency, flags mutually exclusive, both low for zero.
module sign_classifier
  import sign_class_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in,
  output logic              positive_flag,
  output logic              negative_flag
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      positive_flag <= 1'b0;
      negative_flag <= 1'b0;
    end else begin
      positive_flag <= !in[DATA_W-1] && (|in);
      negative_flag <= in[DATA_W-1];
    end
  end

endmodule

// File: rtl/sign_class_arbiter.sv
// Round-robin arbiter sharing one sign classifier among NUM_REQ requesters,
// with per-requester response handshake and saturating per-class counters.
module sign_class_arbiter
  import sign_class_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic                      rsp_pos,
  output logic                      rsp_neg,
  output logic                      rsp_zero,
  output logic                      busy,
  output logic [CNT_W-1:0]          pos_cnt,
  output logic [CNT_W-1:0]          neg_cnt,
  output logic [CNT_W-1:0]          zero_cnt
);

  localparam int GNT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // First valid requester strictly after last, wrapping around.
  function automatic logic [GNT_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [GNT_W-1:0]   last);
    logic [GNT_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last) + off) % NUM_REQ;
      if (!found && valid[idx]) begin
        found = 1'b1;
        pick  = GNT_W'(idx);
      end
    end
    return pick;
  endfunction

  state_e             state_reg, state_next;
  logic [GNT_W-1:0]   gnt_reg, last_grant_reg, pick;
  logic [DATA_W-1:0]  data_reg;
  logic [CNT_W-1:0]   pos_cnt_reg, neg_cnt_reg, zero_cnt_reg;
  logic               pos_flag, neg_flag;
  logic               accept, done, in_resp;
  sign_class_e        rsp_class;

  assign pick      = rr_pick(req_valid, last_grant_reg);
  assign in_resp   = (state_reg == ST_RESP);
  assign rsp_class = flags_to_class(pos_flag, neg_flag);

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (|req_valid) begin
          accept     = 1'b1;
          state_next = ST_CLASSIFY;
        end
      end
      ST_CLASSIFY: state_next = ST_RESP;
      ST_RESP: begin
        if (rsp_ready[gnt_reg]) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      gnt_reg        <= '0;
      last_grant_reg <= GNT_W'(NUM_REQ - 1);
      data_reg       <= '0;
      pos_cnt_reg    <= '0;
      neg_cnt_reg    <= '0;
      zero_cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        gnt_reg  <= pick;
        data_reg <= req_data[pick*DATA_W +: DATA_W];
      end
      if (done) begin
        last_grant_reg <= gnt_reg;
        // Counters stick at all-ones rather than wrapping.
        case (rsp_class)
          SC_POS:  if (pos_cnt_reg  != '1) pos_cnt_reg  <= pos_cnt_reg  + 1'b1;
          SC_NEG:  if (neg_cnt_reg  != '1) neg_cnt_reg  <= neg_cnt_reg  + 1'b1;
          default: if (zero_cnt_reg != '1) zero_cnt_reg <= zero_cnt_reg + 1'b1;
        endcase
      end
    end
  end

  sign_classifier #(.DATA_W(DATA_W)) u_classifier (
    .clk           (clk),
    .rst_n         (rst_n),
    .in            (data_reg),
    .positive_flag (pos_flag),
    .negative_flag (neg_flag)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign req_ready[gi] = accept && (pick == GNT_W'(gi));
    assign rsp_valid[gi] = in_resp && (gnt_reg == GNT_W'(gi));
  end

  assign rsp_pos  = in_resp && pos_flag;
  assign rsp_neg  = in_resp && neg_flag;
  assign rsp_zero = in_resp && !pos_flag && !neg_flag;
  assign busy     = (state_reg != ST_IDLE);
  assign pos_cnt  = pos_cnt_reg;
  assign neg_cnt  = neg_cnt_reg;
  assign zero_cnt = zero_cnt_reg;

endmodule

// File: tb/tb_sign_class_arbiter.sv
// Randomized and directed bench for sign_class_arbiter against a transaction-level model.
module tb_sign_class_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready = '0;
  logic            rsp_pos, rsp_neg, rsp_zero, busy;
  logic [CW-1:0]   pos_cnt, neg_cnt, zero_cnt;

  sign_class_arbiter #(.NUM_REQ(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_pos(rsp_pos), .rsp_neg(rsp_neg), .rsp_zero(rsp_zero), .busy(busy),
    .pos_cnt(pos_cnt), .neg_cnt(neg_cnt), .zero_cnt(zero_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: one outstanding transaction, response two edges after acceptance.
  bit          m_pending = 0;
  int          m_age = 0;
  int          m_gnt = 0;
  int          m_last = N - 1;
  logic [DW-1:0] m_data = '0;
  int          m_cnt[3] = '{0, 0, 0};
  int          acc_idx = -1;
  int          cyc = 0;
  int          grants[$];
  int          grant_cyc[$];
  logic [DW-1:0] tx_q[N][$];

  function automatic int rr_ref(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // 0 = zero, 1 = positive, 2 = negative
  function automatic int class_of(input logic [DW-1:0] d);
    logic signed [DW-1:0] sd;
    sd = d;
    if (sd > 0) return 1;
    if (sd < 0) return 2;
    return 0;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (acc_idx == i) req_valid[i] = 1'b0;
      if (!req_valid[i] && tx_q[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_data[i*DW +: DW] = tx_q[i].pop_front();
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] exp_rr, exp_rv;
    logic ep, en, ez;
    int p, k;
    #1;
    exp_rr = '0; exp_rv = '0; ep = 0; en = 0; ez = 0;
    if (!m_pending) begin
      p = rr_ref(req_valid, m_last);
      if (p >= 0) exp_rr[p] = 1'b1;
    end else if (m_age >= 2) begin
      exp_rv[m_gnt] = 1'b1;
      k = class_of(m_data);
      ep = (k == 1); en = (k == 2); ez = (k == 0);
    end
    check("req_ready", 32'(req_ready), 32'(exp_rr));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    check("rsp_pos",   32'(rsp_pos),   32'(ep));
    check("rsp_neg",   32'(rsp_neg),   32'(en));
    check("rsp_zero",  32'(rsp_zero),  32'(ez));
    check("busy",      32'(busy),      32'(m_pending));
    check("pos_cnt",   32'(pos_cnt),   32'(m_cnt[1]));
    check("neg_cnt",   32'(neg_cnt),   32'(m_cnt[2]));
    check("zero_cnt",  32'(zero_cnt),  32'(m_cnt[0]));
    @(posedge clk);
    cyc++;
    acc_idx = -1;
    if (!rst_n) begin
      m_pending = 0; m_last = N - 1; m_cnt = '{0, 0, 0};
    end else if (!m_pending) begin
      p = rr_ref(req_valid, m_last);
      if (p >= 0) begin
        m_pending = 1; m_age = 1; m_gnt = p;
        m_data = req_data[p*DW +: DW];
        acc_idx = p;
        grants.push_back(p);
        grant_cyc.push_back(cyc);
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (rsp_ready[m_gnt]) begin
      k = class_of(m_data);
      if (m_cnt[k] < (1 << CW) - 1) m_cnt[k]++;
      m_last = m_gnt;
      m_pending = 0;
      $display("RSP req=%0d data=%04h class=%s", m_gnt, m_data,
               (k == 1) ? "pos" : (k == 2) ? "neg" : "zero");
    end
    #1;
  endtask

  function automatic bit work_left();
    bit w;
    w = m_pending || (req_valid != '0);
    for (int i = 0; i < N; i++) if (tx_q[i].size() > 0) w = 1;
    return w;
  endfunction

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while (work_left() && n < maxc) begin
      drive();
      step();
      n++;
    end
    check("drain_busy", 32'(busy), 32'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive();
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [DW-1:0] rand_sample();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'h7FFF;
      3: return 16'hFFFF;
      4: return 16'h0001;
      default: return DW'($urandom);
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    step();
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_pos_cnt", 32'(pos_cnt), 32'(0));
    rst_n = 1'b1;

    // Single positive sample from requester 0
    rsp_ready = '1;
    tx_q[0].push_back(16'h000A);
    drain(50);
    check("tp1_grant", 32'(grants[grants.size()-1]), 32'(0));
    check("tp1_pos_cnt", 32'(pos_cnt), 32'(1));

    // Negative then zero from requester 2
    tx_q[2].push_back(16'hFFFB);
    tx_q[2].push_back(16'h0000);
    drain(50);
    check("tp2_neg_cnt", 32'(neg_cnt), 32'(1));
    check("tp2_zero_cnt", 32'(zero_cnt), 32'(1));

    // All requesters continuously valid: strict rotation, one grant per 3 cycles
    do_reset();
    grants.delete();
    grant_cyc.delete();
    for (int i = 0; i < N; i++) begin
      tx_q[i].push_back(16'h1111 * (i + 1));
      tx_q[i].push_back(16'h8001 + i);
    end
    drain(100);
    check("tp3_grant_count", 32'(grants.size()), 32'(2 * N));
    for (int k = 0; k < grants.size(); k++) begin
      check("tp3_order", 32'(grants[k]), 32'(k % N));
      if (k > 0) check("tp3_spacing", 32'(grant_cyc[k] - grant_cyc[k-1]), 32'(3));
    end

    // Response back-pressure on requester 1 while requester 3 waits
    rsp_ready = '0;
    tx_q[1].push_back(16'h8000);
    drive(); step();
    tx_q[3].push_back(16'h1234);
    drive(); step();
    for (int k = 0; k < 5; k++) begin
      drive(); step();
      check("tp4_hold_valid", 32'(rsp_valid), 32'(4'b0010));
      check("tp4_hold_neg", 32'(rsp_neg), 32'(1));
      check("tp4_hold_ready", 32'(req_ready), 32'(0));
    end
    rsp_ready = 4'b0010;
    drive(); step();
    check("tp4_next_ready", 32'(req_ready), 32'(4'b1000));
    rsp_ready = '1;
    drain(50);
    check("tp4_next_grant", 32'(grants[grants.size()-1]), 32'(3));

    // Positive counter saturation
    do_reset();
    for (int k = 0; k < 300; k++) tx_q[0].push_back(16'h7FFF);
    drain(1200);
    check("tp5_pos_sat", 32'(pos_cnt), 32'(255));
    check("tp5_neg_cnt", 32'(neg_cnt), 32'(0));
    check("tp5_zero_cnt", 32'(zero_cnt), 32'(0));

    // Reset while requester 3 is being classified
    tx_q[3].push_back(16'h4321);
    drive(); step();
    check("tp6_classify_busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    drive(); step();
    rst_n = 1'b1;
    check("tp6_busy", 32'(busy), 32'(0));
    check("tp6_rsp_valid", 32'(rsp_valid), 32'(0));
    check("tp6_pos_cnt", 32'(pos_cnt), 32'(0));
    tx_q[0].push_back(16'h0005);
    tx_q[3].push_back(16'h0006);
    drive(); step();
    check("tp6_first_grant", 32'(grants[grants.size()-1]), 32'(0));
    drain(50);

    // Random traffic, random back-pressure, occasional withdrawn requests
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && tx_q[i].size() == 0 && $urandom_range(0, 3) == 0)
          tx_q[i].push_back(rand_sample());
        if (req_valid[i] && acc_idx != i && $urandom_range(0, 15) == 0)
          req_valid[i] = 1'b0;
      end
      rsp_ready = N'($urandom);
      drive();
      step();
    end
    rsp_ready = '1;
    drain(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
